// File: rtl/clock_ctrl.sv
// Run/set control for a 12-hour BCD clock: 1 s prescaler, counter enables,
// AM/PM tracking and a RUN -> SET_HR -> SET_MIN mode machine with blink gating.
module clock_ctrl #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_mode,
  input  logic       i_inc,
  input  logic [7:0] i_sec_q,
  input  logic [7:0] i_min_q,
  input  logic [7:0] i_hr_q,
  output logic       o_sec_en,
  output logic       o_min_en,
  output logic       o_hr_en,
  output logic       o_sec_clr,
  output logic       o_pm,
  output logic [1:0] o_mode,
  output logic       o_blink
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);
  localparam logic [W-1:0] HALF = W'(TICK_DIV / 2);

  typedef enum logic [1:0] {
    RUN     = 2'b00,
    SET_HR  = 2'b01,
    SET_MIN = 2'b10
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [W-1:0] r_presc;
  logic [W-1:0] w_presc_next;
  logic         r_sec_en, r_min_en, r_hr_en, r_sec_clr, r_pm, r_blink;
  logic         w_sec_en_next, w_min_en_next, w_hr_en_next;
  logic         w_sec_clr_next, w_pm_next, w_blink_next;
  logic         w_tick, w_inc, w_sec59, w_min59, w_hr11, w_pm_flip;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RUN:     if (i_mode) w_state_next = SET_HR;
      SET_HR:  if (i_mode) w_state_next = SET_MIN;
      SET_MIN: if (i_mode) w_state_next = RUN;
      default: w_state_next = RUN;
    endcase

    w_sec59 = (i_sec_q == 8'h59);
    w_min59 = (i_min_q == 8'h59);
    w_hr11  = (i_hr_q == 8'h11);
    w_tick  = (r_state == RUN) && (r_presc == LAST);
    // A mode pulse wins over a coincident increment pulse.
    w_inc   = i_inc && !i_mode;

    w_sec_clr_next = (r_state == SET_MIN) && i_mode;
    // Returning to RUN restarts the second so the first tick is a full period away.
    if (w_sec_clr_next || (r_presc == LAST)) w_presc_next = '0;
    else                                     w_presc_next = r_presc + 1'b1;

    w_sec_en_next = w_tick;
    w_min_en_next = (w_tick && w_sec59) || ((r_state == SET_MIN) && w_inc);
    w_hr_en_next  = (w_tick && w_sec59 && w_min59) || ((r_state == SET_HR) && w_inc);
    w_pm_flip     = (w_tick && w_hr11 && w_min59 && w_sec59) ||
                    ((r_state == SET_HR) && w_inc && w_hr11);
    w_pm_next     = r_pm ^ w_pm_flip;
    w_blink_next  = ((w_state_next == SET_HR) || (w_state_next == SET_MIN)) &&
                    (w_presc_next < HALF);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= RUN;
      r_presc   <= '0;
      r_sec_en  <= 1'b0;
      r_min_en  <= 1'b0;
      r_hr_en   <= 1'b0;
      r_sec_clr <= 1'b0;
      r_pm      <= 1'b0;
      r_blink   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_presc   <= w_presc_next;
      r_sec_en  <= w_sec_en_next;
      r_min_en  <= w_min_en_next;
      r_hr_en   <= w_hr_en_next;
      r_sec_clr <= w_sec_clr_next;
      r_pm      <= w_pm_next;
      r_blink   <= w_blink_next;
    end
  end

  assign o_sec_en  = r_sec_en;
  assign o_min_en  = r_min_en;
  assign o_hr_en   = r_hr_en;
  assign o_sec_clr = r_sec_clr;
  assign o_pm      = r_pm;
  assign o_mode    = r_state;
  assign o_blink   = r_blink;

endmodule

// File: tb/tb_clock_ctrl.sv
// Scoreboard bench for clock_ctrl with TICK_DIV=10: stimulus queues expected
// pulses by cycle number, a negedge monitor pops and compares every pulse seen.
module tb_clock_ctrl;
  localparam int TD = 10;

  logic       clk = 1'b0;
  logic       i_rst, i_mode, i_inc;
  logic [7:0] i_sec_q, i_min_q, i_hr_q;
  logic       o_sec_en, o_min_en, o_hr_en, o_sec_clr, o_pm, o_blink;
  logic [1:0] o_mode;

  always #5 clk = ~clk;

  clock_ctrl #(.TICK_DIV(TD)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_mode(i_mode), .i_inc(i_inc),
    .i_sec_q(i_sec_q), .i_min_q(i_min_q), .i_hr_q(i_hr_q),
    .o_sec_en(o_sec_en), .o_min_en(o_min_en), .o_hr_en(o_hr_en),
    .o_sec_clr(o_sec_clr), .o_pm(o_pm), .o_mode(o_mode), .o_blink(o_blink)
  );

  // Number of rising edges seen so far; stable when read at the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected pulse: cycle it is visible in and {sec_en, min_en, hr_en, sec_clr}.
  typedef struct {
    int         c;
    logic [3:0] f;
  } ev_t;
  ev_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", nm, cyc, act, exp);
    end
  endtask

  task automatic push(input int c, input logic [3:0] f);
    ev_t e;
    e.c = c;
    e.f = f;
    q.push_back(e);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: any enable/clear pulse must match the head of the queue.
  always @(negedge clk) begin
    logic [3:0] f;
    ev_t        e;
    f = {o_sec_en, o_min_en, o_hr_en, o_sec_clr};
    if ((|f) === 1'b1) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse cyc=%0d got=%b expected none", cyc, f);
      end else begin
        e = q.pop_front();
        if (e.c != cyc || e.f !== f) begin
          errors++;
          $display("FAIL pulse cyc=%0d flags=%b expected cyc=%0d flags=%b", cyc, f, e.c, e.f);
        end else begin
          $display("pulse ok cyc=%0d flags=%b", cyc, f);
        end
      end
    end
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int rel2;
    i_rst = 1'b1; i_mode = 1'b0; i_inc = 1'b0;
    i_sec_q = 8'h00; i_min_q = 8'h00; i_hr_q = 8'h12;

    // Reset held for two edges.
    wait_until(2);
    chk("rst_mode", int'(o_mode), 0);
    chk("rst_pm", int'(o_pm), 0);
    chk("rst_blink", int'(o_blink), 0);
    chk("rst_enables", int'({o_sec_en, o_min_en, o_hr_en, o_sec_clr}), 0);
    i_rst = 1'b0;
    rel = cyc;

    // Free-running RUN: tick every 10 cycles, first one 10 after release.
    for (int i = 1; i <= 5; i++) push(rel + TD * i, 4'b1000);
    wait_until(rel + 50);

    // 11:59:59 rollover carries everything and flips to PM.
    i_hr_q = 8'h11; i_min_q = 8'h59; i_sec_q = 8'h59;
    push(rel + 60, 4'b1110);
    wait_until(rel + 59);
    chk("pm_before_roll", int'(o_pm), 0);
    wait_until(rel + 60);
    i_hr_q = 8'h12; i_min_q = 8'h00; i_sec_q = 8'h00;
    wait_until(rel + 61);
    chk("pm_after_roll", int'(o_pm), 1);

    // Enter SET_HR and increment from 11: one hr_en, PM flag toggles back.
    wait_until(rel + 62);
    i_mode = 1'b1;
    wait_until(rel + 63);
    i_mode = 1'b0;
    chk("mode_set_hr", int'(o_mode), 1);
    chk("blink_enter", int'(o_blink), 1);
    i_hr_q = 8'h11;
    wait_until(rel + 64);
    i_inc = 1'b1;
    push(rel + 65, 4'b0010);
    wait_until(rel + 65);
    i_inc = 1'b0;
    i_hr_q = 8'h12;
    chk("pm_set_hr_inc", int'(o_pm), 0);

    // 30 cycles in SET_HR: no seconds ticks, blink follows prescaler half.
    for (int k = rel + 66; k <= rel + 95; k++) begin
      wait_until(k);
      chk("blink", int'(o_blink), (((k - rel) % TD) < (TD / 2)) ? 1 : 0);
    end
    chk("mode_still_set_hr", int'(o_mode), 1);

    // SET_MIN, one minute increment, back to RUN with seconds clear.
    i_mode = 1'b1;
    wait_until(rel + 96);
    i_mode = 1'b0;
    chk("mode_set_min", int'(o_mode), 2);
    push(rel + 99, 4'b0100);
    push(rel + 102, 4'b0001);
    push(rel + 112, 4'b1000);
    wait_until(rel + 98);
    i_inc = 1'b1;
    wait_until(rel + 99);
    i_inc = 1'b0;
    wait_until(rel + 101);
    i_mode = 1'b1;
    wait_until(rel + 102);
    i_mode = 1'b0;
    chk("mode_run_again", int'(o_mode), 0);
    chk("blink_run", int'(o_blink), 0);

    // Increment in RUN is ignored.
    wait_until(rel + 104);
    i_inc = 1'b1;
    wait_until(rel + 105);
    i_inc = 1'b0;

    // Mode and increment together: transition only, no hr_en.
    wait_until(rel + 114);
    i_mode = 1'b1; i_inc = 1'b1;
    wait_until(rel + 115);
    i_mode = 1'b0; i_inc = 1'b0;
    chk("mode_coincide", int'(o_mode), 1);

    // Set PM again, then move to SET_MIN and reset there (with an inc pending).
    i_hr_q = 8'h11;
    wait_until(rel + 118);
    i_inc = 1'b1;
    push(rel + 119, 4'b0010);
    wait_until(rel + 119);
    i_inc = 1'b0;
    i_hr_q = 8'h12;
    chk("pm_set_again", int'(o_pm), 1);
    wait_until(rel + 120);
    i_mode = 1'b1;
    wait_until(rel + 121);
    i_mode = 1'b0;
    chk("mode_set_min_2", int'(o_mode), 2);
    wait_until(rel + 124);
    i_rst = 1'b1; i_inc = 1'b1;
    wait_until(rel + 125);
    i_rst = 1'b0; i_inc = 1'b0;
    chk("rst_mid_set_mode", int'(o_mode), 0);
    chk("rst_mid_set_pm", int'(o_pm), 0);
    chk("rst_mid_set_blink", int'(o_blink), 0);
    rel2 = cyc;
    push(rel2 + TD, 4'b1000);

    wait_until(rel2 + TD + 2);
    chk("queue_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
